clkdiv_multi: RTL
=================

Name: clkdiv_multi

Overview:
- Parametrised successor to the fixed three-output divider.
- Generates NUM_CH independent 50%-duty divided clocks plus one-cycle tick enables from the board oscillator.
- Each channel's half-period is runtime-programmable, with glitch-free update at the channel's terminal count.
- Adds global pause and phase realignment. Sits at the top of the clock design, feeding the seconds, debounce and display-scan logic.

Parameters:
- NUM_CH, 3, number of output channels (1..8).
- CNT_W, 28, half-period counter and divisor width.
- DIV_INIT, {28'd50_000_000, 28'd5_000_000, 28'd50_000}, flattened NUM_CH*CNT_W reset half-periods; ch0 in the LSBs. Defaults give 1 KHz / 10 Hz / 1 Hz at 100 MHz.

Ports:
- XTAL_OSC  in  1  system clock, 100 MHz oscillator.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = channels run; 0 = all counters and outputs hold.
- sync_clr  in  1  one-cycle pulse; realigns all channels to phase 0.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  3  target channel of the write; values >= NUM_CH are ignored.
- cfg_div  in  CNT_W  new half-period in XTAL_OSC cycles.
- clk_out  out  NUM_CH  divided square waves, registered.
- tick  out  NUM_CH  one-cycle pulse per clk_out rising edge, registered.

Behaviour:
- Per channel: counter cnt, active half-period act, pending half-period pend.
- Reset (rst=1 at a XTAL_OSC edge, takes priority over all other inputs):
  - cnt=0, clk_out=0, tick=0.
  - act=pend=DIV_INIT slice.
  - A reset mid-period discards any pending write.
- Run (enable=1, act>0):
  - Each cycle, cnt increments.
  - When cnt==act-1: cnt<=0, clk_out toggles, act<=pend.
  - tick=1 for exactly the cycle in which clk_out has just become 1; otherwise 0.
  - Period = 2*act cycles, duty 50% whenever act is constant across the period.
  - The first rising edge of clk_out occurs act cycles after reset release.
- act==1: clk_out toggles every cycle (XTAL_OSC/2), and tick pulses every 2nd cycle.
- act==0: channel disabled. cnt=0, clk_out held 0, tick=0. pend is copied into act every cycle, so a nonzero write starts the channel on the next cycle from phase 0.
- Hold (enable=0):
  - cnt, clk_out and act are frozen; tick=0.
  - Writes still update pend.
  - Resuming continues from the frozen phase with no extra edge.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - pend[cfg_ch]<=cfg_div.
  - If the same cycle is that channel's terminal count, act takes cfg_div directly (write bypass), so the new value applies at that boundary.
  - A half-period already in progress is never truncated or stretched.
- sync_clr=1 (rst=0), all channels:
  - cnt<=0, clk_out<=0, tick<=0, act<=pend, including a same-cycle write.
  - Takes priority over enable and terminal-count logic.
- Counters never wrap past act-1. A pend/act value of 2^CNT_W-1 is legal.
- Channels are fully independent; simultaneous terminal counts on several channels are all honoured in the same cycle.

Optional Feature:
- Macro CLKDIV_RDBK_EN.
- Defined: adds output cfg_rd_data [CNT_W-1:0] = act[cfg_ch], registered with 1-cycle latency.
  - Reads 0 when cfg_ch>=NUM_CH.
  - Reset value 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- CNT_W=8, DIV_INIT={4,2,1}, release rst:
  - ch0 toggles every cycle, tick0 every 2nd cycle.
  - ch1 period 4.
  - ch2 first rises 4 cycles after release, period 8, tick2 high 1 of 8 cycles.
- ch2 running act=4, write cfg_div=2 at cnt=1: current half-period completes at 4 cycles, then period 4. Write landing exactly at terminal count applies at that same boundary.
- enable=0 for 5 cycles mid-period on ch2: clk_out and cnt frozen, no ticks; after re-enable the remaining half-period length is unchanged.
- Write 0 to ch1: clk_out1 goes low at the next terminal and stays 0. Write 3: ch1 restarts from phase 0 with period 6.
- sync_clr pulse while channels are out of phase: all clk_out=0 next cycle. Subsequent rising edges align to act cycles after the pulse. sync_clr together with rst gives reset values.
- With CLKDIV_RDBK_EN defined: cfg_ch=1 returns 2 one cycle later, and cfg_ch=5 returns 0. Default parameters: clk_out2 period 100_000_000 cycles.

Source files
------------

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH independent 50%-duty clock dividers with one-cycle tick enables.
// Each channel counts XTAL_OSC cycles up to its active half-period (act), toggles clk_out
// and loads the pending half-period (pend) at that terminal count, so divisor changes are
// glitch-free. A global enable pauses every channel; sync_clr realigns all to phase 0.
// Optional feature: define CLKDIV_RDBK_EN to add the registered cfg_rd_data readback port.
module clkdiv_multi #(
  parameter int unsigned                    NUM_CH   = 3,
  parameter int unsigned                    CNT_W    = 28,
  parameter logic [NUM_CH*CNT_W-1:0]        DIV_INIT = {28'd50_000_000, 28'd5_000_000,
                                                        28'd50_000}
) (
  input  logic              XTAL_OSC,
  input  logic              rst,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLKDIV_RDBK_EN
  ,
  output logic [CNT_W-1:0]  cfg_rd_data
`endif
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  act_q  [NUM_CH];
  logic [CNT_W-1:0]  act_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Per-channel next state: sync_clr > hold > disabled (act==0) > terminal count > count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // A write to this channel is visible to act in the same cycle (write bypass).
      pend_d[i] = (cfg_we && ({1'b0, cfg_ch} == 4'(i))) ? cfg_div : pend_q[i];
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      if (sync_clr) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        act_d[i] = pend_d[i];
      end else if (!enable) begin
        // Frozen: keep phase, suppress ticks.
      end else if (act_q[i] == '0) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        act_d[i] = pend_d[i];
      end else if (cnt_q[i] == act_q[i] - One) begin
        cnt_d[i] = '0;
        act_d[i] = pend_d[i];
        if (pend_d[i] == '0) begin
          // Channel is being disabled: park the output low rather than raise it.
          clk_d[i] = 1'b0;
        end else begin
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + One;
      end
    end
  end

  // Channel state registers with synchronous reset to the DIV_INIT slices.
  always_ff @(posedge XTAL_OSC) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
        pend_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

`ifdef CLKDIV_RDBK_EN
  logic [CNT_W-1:0] rd_d, rd_q;

  // Select act of the addressed channel; out-of-range channels read as zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ({1'b0, cfg_ch} == 4'(i)) begin
        rd_d = act_q[i];
      end
    end
  end

  // Readback register, one cycle behind cfg_ch.
  always_ff @(posedge XTAL_OSC) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign cfg_rd_data = rd_q;
`endif

endmodule
